// File: rtl/alu_result_stage.sv
// ALU result stage: captures ALU outputs, derives N/Z/C/V flags and
// hands results downstream through a 2-entry skid buffer.
module alu_result_stage #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_A,
  input  logic [WIDTH-1:0] in_B,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_Y,
  input  logic             in_Cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_Y,
  output logic [2:0]       out_op,
  output logic [3:0]       out_flags,
  output logic [CNT_W-1:0] res_count
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic [2:0]       op;
    logic [3:0]       flags;
  } ent_t;

  state_t     state_q, state_d;
  ent_t       main_q, skid_q, cap;
  logic       valid_q, ready_q;
  logic [CNT_W-1:0] cnt_q;
  logic       in_fire, out_fire;
  logic       main_ld, skid_ld, from_skid;
  logic       f_n, f_z, f_c, f_v;
  logic       a_s, b_s, y_s;
  logic       unused_ok;

  assign a_s = in_A[WIDTH-1];
  assign b_s = in_B[WIDTH-1];
  assign y_s = in_Y[WIDTH-1];

  // Only the sign bits of the operands feed the overflow flag.
  assign unused_ok = ^{in_A[WIDTH-2:0], in_B[WIDTH-2:0]};

  assign in_fire  = in_valid & ready_q;
  assign out_fire = valid_q & out_ready;

  // Flag derivation from the incoming ALU result.
  always_comb begin
    f_n = y_s;
    f_z = (in_Y == '0);
    f_c = 1'b0;
    f_v = 1'b0;
    unique case (1'b1)
      (in_op == OP_ADD): begin
        f_c = in_Cout;
        f_v = (a_s == b_s) && (y_s != a_s);
      end
      (in_op == OP_SUB): begin
        f_c = in_Cout;
        f_v = (a_s != b_s) && (y_s != a_s);
      end
      (in_op == OP_SHL),
      (in_op == OP_SHR): f_c = in_Cout;
      default: ;
    endcase
  end

  assign cap = '{y: in_Y, op: in_op, flags: {f_n, f_z, f_c, f_v}};

  // Next-state and load controls of the skid buffer.
  always_comb begin
    state_d   = state_q;
    main_ld   = 1'b0;
    skid_ld   = 1'b0;
    from_skid = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_ld = 1'b1;
          state_d = ONE;
        end
      end
      ONE: begin
        if (out_fire && in_fire) begin
          main_ld = 1'b1;
        end else if (out_fire) begin
          state_d = EMPTY;
        end else if (in_fire) begin
          skid_ld = 1'b1;
          state_d = FULL;
        end
      end
      FULL: begin
        if (out_fire) begin
          main_ld   = 1'b1;
          from_skid = 1'b1;
          state_d   = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // State plus registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      valid_q <= (state_d != EMPTY);
      ready_q <= (state_d != FULL);
    end
  end

  // Main and skid entry storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (main_ld) main_q <= from_skid ? skid_q : cap;
      if (skid_ld) skid_q <= cap;
    end
  end

  // Delivered-result counter, wraps silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else if (out_fire) cnt_q <= cnt_q + 1'b1;
  end

  assign in_ready  = ready_q;
  assign out_valid = valid_q;
  assign out_Y     = main_q.y;
  assign out_op    = main_q.op;
  assign out_flags = main_q.flags;
  assign res_count = cnt_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: scoreboard of captured results
// checked against delivered outputs, plus directed cases.
module tb_alu_result_stage;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_A;
  logic [7:0] in_B;
  logic [2:0] in_op;
  logic [7:0] in_Y;
  logic       in_Cout;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_Y;
  logic [2:0] out_op;
  logic [3:0] out_flags;
  logic [15:0] res_count;

  logic       in_valid4;
  logic       in_ready4;
  logic       out_valid4;
  logic [7:0] out_Y4;
  logic [2:0] out_op4;
  logic [3:0] out_flags4;
  logic [3:0] res_count4;

  int tests;
  int fails;

  logic [14:0] sb_q[$];
  logic        pv;
  logic        pr;
  logic [15:0] pcap;

  alu_result_stage #(.WIDTH(8), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_A(in_A), .in_B(in_B), .in_op(in_op),
    .in_Y(in_Y), .in_Cout(in_Cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_Y(out_Y), .out_op(out_op),
    .out_flags(out_flags), .res_count(res_count)
  );

  alu_result_stage #(.WIDTH(8), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .in_A(in_A), .in_B(in_B), .in_op(in_op),
    .in_Y(in_Y), .in_Cout(in_Cout),
    .out_valid(out_valid4), .out_ready(1'b1),
    .out_Y(out_Y4), .out_op(out_op4),
    .out_flags(out_flags4), .res_count(res_count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] mflags(input logic [7:0] a,
                                        input logic [7:0] b,
                                        input logic [7:0] y,
                                        input logic       co,
                                        input logic [2:0] op);
    logic n, z, c, v;
    n = y[7];
    z = (y == 8'h00);
    c = 1'b0;
    v = 1'b0;
    if (op == 3'd0 || op == 3'd1 || op == 3'd6 || op == 3'd7)
      c = co;
    if (op == 3'd0)
      v = (a[7] == b[7]) && (y[7] != a[7]);
    if (op == 3'd1)
      v = (a[7] != b[7]) && (y[7] != a[7]);
    return {n, z, c, v};
  endfunction

  // Scoreboard: push on input handshake, pop on output handshake,
  // and require held outputs while stalled.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      pv = 1'b0;
      pr = 1'b1;
    end else begin
      if (pv && !pr)
        chk("stable", 32'({out_valid, out_Y, out_op, out_flags}),
            32'(pcap));
      if (out_valid && out_ready) begin
        chk("sb_nonempty", 32'(sb_q.size() != 0), 1);
        if (sb_q.size() != 0)
          chk("sb_data", 32'({out_Y, out_op, out_flags}),
              32'(sb_q.pop_front()));
      end
      if (in_valid && in_ready)
        sb_q.push_back({in_Y, in_op,
                        mflags(in_A, in_B, in_Y, in_Cout, in_op)});
      pv   = out_valid;
      pr   = out_ready;
      pcap = {out_valid, out_Y, out_op, out_flags};
    end
  end

  task automatic drive(input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] op, input logic [7:0] y,
                       input logic co);
    in_A     = a;
    in_B     = b;
    in_op    = op;
    in_Y     = y;
    in_Cout  = co;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    chk("rst_ovalid", 32'(out_valid), 0);
    chk("rst_iready", 32'(in_ready), 1);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    int acc;
    int cyc;
    int w;
    tests     = 0;
    fails     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_valid4 = 1'b0;
    out_ready = 1'b0;
    in_A = '0; in_B = '0; in_op = '0; in_Y = '0; in_Cout = 1'b0;
    #12;
    chk("rst_ovalid", 32'(out_valid), 0);
    chk("rst_iready", 32'(in_ready), 1);
    chk("rst_outy", 32'(out_Y), 0);
    chk("rst_outop", 32'(out_op), 0);
    chk("rst_flags", 32'(out_flags), 0);
    chk("rst_count", 32'(res_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // ADD overflow into the sign bit.
    out_ready = 1'b1;
    drive(8'h7F, 8'h01, 3'd0, 8'h80, 1'b0);
    chk("add_valid", 32'(out_valid), 1);
    chk("add_y", 32'(out_Y), 32'h80);
    chk("add_flags", 32'(out_flags), 32'b1001);
    step();
    chk("add_count", 32'(res_count), 1);

    // SUB to zero with carry, then AND which masks the carry.
    drive(8'h05, 8'h05, 3'd1, 8'h00, 1'b1);
    chk("sub_flags", 32'(out_flags), 32'b0110);
    drive(8'hF0, 8'h0F, 3'd2, 8'h00, 1'b1);
    chk("and_op", 32'(out_op), 2);
    chk("and_flags", 32'(out_flags), 32'b0100);
    step();

    // Backpressure fills the skid entry.
    out_ready = 1'b0;
    drive(8'h11, 8'h11, 3'd3, 8'h11, 1'b0);
    chk("bp_ready1", 32'(in_ready), 1);
    drive(8'h22, 8'h22, 3'd3, 8'h22, 1'b0);
    chk("bp_ready0", 32'(in_ready), 0);
    chk("bp_hold", 32'(out_Y), 32'h11);
    step();
    chk("bp_hold2", 32'(out_Y), 32'h11);
    out_ready = 1'b1;
    step();
    chk("bp_second", 32'(out_Y), 32'h22);
    chk("bp_ready_back", 32'(in_ready), 1);
    step();
    chk("bp_empty", 32'(out_valid), 0);

    // Back-to-back streaming.
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_A    = 8'(i);
      in_B    = 8'(3 * i);
      in_op   = 3'(i);
      in_Y    = 8'(i * 7 + 1);
      in_Cout = 1'(i);
      chk("stream_ready", 32'(in_ready), 1);
      step();
      chk("stream_valid", 32'(out_valid), 1);
    end
    in_valid = 1'b0;
    step();
    chk("stream_count", 32'(res_count), 20);

    // Random valid/ready traffic.
    acc = 0;
    cyc = 0;
    while (acc < 1000 && cyc < 20000) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_A      = 8'($urandom);
      in_B      = 8'($urandom);
      in_op     = 3'($urandom_range(0, 7));
      in_Y      = 8'($urandom);
      in_Cout   = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      if (in_valid && in_ready) acc++;
      step();
      cyc++;
    end
    in_valid = 1'b0;
    chk("rand_accepted", 32'(acc), 1000);
    out_ready = 1'b1;
    w = 0;
    while (sb_q.size() != 0 && w < 10) begin
      step();
      w++;
    end
    step();
    chk("rand_drain", 32'(sb_q.size()), 0);

    // Asynchronous reset while full.
    out_ready = 1'b0;
    drive(8'h01, 8'h02, 3'd0, 8'h03, 1'b0);
    drive(8'h04, 8'h05, 3'd0, 8'h09, 1'b0);
    chk("full_ready", 32'(in_ready), 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ovalid", 32'(out_valid), 0);
    chk("arst_iready", 32'(in_ready), 1);
    chk("arst_count", 32'(res_count), 0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    step();

    // Narrow counter wraps after 16 transfers.
    in_valid4 = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_Y = 8'(i);
      step();
    end
    in_valid4 = 1'b0;
    step();
    chk("wrap_count", 32'(res_count4), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
